ips2l_pcie_dma_mwr_req_arb: RTL and testbench
=============================================

Name: ips2l_pcie_dma_mwr_req_arb

Overview:
- Round-robin arbiter and sequencer placed in front of the DMA memory-write TX controller.
- Shares the single MWr32/MWr64 request port between CH_NUM DMA channels, and latches the granted channel's length, address, data and user-define flag.
- Drives the TX controller's req/ack handshake and holds off the next grant until the TX controller's busy drops.
- Reports per-channel completion, error and timeout.

Parameters:
- CH_NUM, 4: number of requesting channels (2..8).
- ACK_TIMEOUT, 1024: maximum cycles in REQ waiting for an ack before the request is abandoned.

Ports:
- clk  input  1  core clock (gen1 62.5MHz, gen2 125MHz).
- rst_n  input  1  asynchronous active-low reset.
- i_arb_en  input  1  arbitration enable; 0 blocks new grants only.
- i_ch_req  input  CH_NUM  per-channel request level, held until o_ch_done or o_ch_err.
- i_ch_is64  input  CH_NUM  1 = MWr64, 0 = MWr32.
- i_ch_udf  input  CH_NUM  user-define single-DW data flag.
- i_ch_length  input  CH_NUM*10  DW length; channel k occupies bits [10k+9:10k].
- i_ch_addr  input  CH_NUM*64  target address; channel k occupies [64k+63:64k].
- i_ch_data  input  CH_NUM*32  user-define DW; channel k occupies [32k+31:32k].
- o_ch_gnt  output  CH_NUM  one-hot level, high from grant until done/err.
- o_ch_done  output  CH_NUM  one-cycle completion pulse.
- o_ch_err  output  CH_NUM  one-cycle pulse on zero-length reject or ack timeout.
- o_mwr32_req  output  1  to TX ctrl.
- i_mwr32_req_ack  input  1  from TX ctrl.
- o_mwr64_req  output  1  to TX ctrl.
- i_mwr64_req_ack  input  1  from TX ctrl.
- o_req_length  output  10  latched length.
- o_req_addr  output  64  latched address.
- o_req_data  output  32  latched data.
- o_user_define_data_flag  output  1  latched udf.
- i_mwr_tx_busy  input  1  TX ctrl busy.

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer = 0, timeout counter = 0.
- States:
  - IDLE: grant when i_arb_en && |i_ch_req && !i_mwr_tx_busy && !ack32 && !ack64. Winner is the first requesting channel at or after the pointer, modulo CH_NUM. At the grant edge, latch the winner's fields onto o_req_*, set o_ch_gnt, and go to CHECK.
  - CHECK (1 cycle): if latched length == 0 && !udf, pulse o_ch_err and go to RELEASE (TX ctrl would hang). Otherwise go to REQ.
  - REQ: assert o_mwr64_req if is64, else o_mwr32_req. Hold until the matching ack is high, then go to WAIT_TX; the req deasserts at that same edge. The counter increments each REQ cycle; on reaching ACK_TIMEOUT-1, drop req, pulse o_ch_err, go to RELEASE.
  - WAIT_TX: when !i_mwr_tx_busy && !ack, pulse o_ch_done and go to RELEASE. TX ctrl busy is set on the cycle after ack, so no busy-seen flag is needed.
  - RELEASE (1 cycle): clear o_ch_gnt, set pointer = granted index + 1 (wraps CH_NUM-1 to 0), clear counter, go to IDLE.
- Latency: a lone request granted at edge T asserts req at T+2.
- o_req_* fields are stable from grant to RELEASE and ignore input changes.
- A channel dropping i_ch_req mid-service does not abort it; done/err still pulses.
- i_arb_en deasserted mid-service: the current transfer completes, then no new grant is made.
- A request for the channel just serviced, with other channels pending, loses; the pointer guarantees fairness.
- Ack for the wrong type in REQ is ignored and counts toward timeout.

Test Plan:
- ch0 only, MWr32, len=32, addr=0x1000; model acks 1 cycle after req, busy 40 cycles -> o_mwr32_req high from T+2 until ack; o_req_length=32; o_ch_done[0] pulses once after busy falls; pointer = 1.
- ch0..ch3 all request continuously -> grants in order 0,1,2,3,0; each done precedes the next req; no two o_ch_gnt bits high together.
- ch2 MWr64, udf=1, len=1, data=0xA5A5_0001, addr=0x1_0000_0040 -> o_mwr64_req asserted; o_req_addr=0x1_0000_0040; o_user_define_data_flag=1; done[2].
- ch1 len=0, udf=0 -> no req asserted; o_ch_err[1] pulses 2 cycles after grant; next grant goes to ch2 if it is requesting.
- Ack never returned, ACK_TIMEOUT=16 -> req drops after 16 REQ cycles; o_ch_err pulses; arbiter returns to IDLE.
- rst_n pulled low during WAIT_TX -> all outputs 0 immediately; pointer = 0; on release, a fresh grant goes to the lowest requester.

Source files
------------

// File: rtl/ips2l_pcie_dma_mwr_req_arb.sv
// rtl/ips2l_pcie_dma_mwr_req_arb.sv - round-robin MWr request arbiter/sequencer for the DMA TX controller
module ips2l_pcie_dma_mwr_req_arb #(
  parameter int CH_NUM      = 4,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_arb_en,
  input  logic [CH_NUM-1:0]    i_ch_req,
  input  logic [CH_NUM-1:0]    i_ch_is64,
  input  logic [CH_NUM-1:0]    i_ch_udf,
  input  logic [CH_NUM*10-1:0] i_ch_length,
  input  logic [CH_NUM*64-1:0] i_ch_addr,
  input  logic [CH_NUM*32-1:0] i_ch_data,
  output logic [CH_NUM-1:0]    o_ch_gnt,
  output logic [CH_NUM-1:0]    o_ch_done,
  output logic [CH_NUM-1:0]    o_ch_err,
  output logic                 o_mwr32_req,
  input  logic                 i_mwr32_req_ack,
  output logic                 o_mwr64_req,
  input  logic                 i_mwr64_req_ack,
  output logic [9:0]           o_req_length,
  output logic [63:0]          o_req_addr,
  output logic [31:0]          o_req_data,
  output logic                 o_user_define_data_flag,
  input  logic                 i_mwr_tx_busy
);

  localparam int IW = $clog2(CH_NUM);
  localparam int CW = $clog2(ACK_TIMEOUT);

  typedef enum logic [2:0] {IDLE, CHECK, REQ, WAIT_TX, RELEASE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, gnt_idx, win_idx, sel_idx;
  logic [IW:0]     sum;
  logic            win_vld, grant, fail, fail_set, req_is64, ack_hit, req_on;
  logic [CW-1:0]   cnt;

  // Scan from the highest offset down so the nearest requester at/after ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    sum     = '0;
    sel_idx = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(CH_NUM))
        sum = sum - (IW+1)'(CH_NUM);
      sel_idx = sum[IW-1:0];
      if (i_ch_req[sel_idx]) begin
        win_vld = 1'b1;
        win_idx = sel_idx;
      end
    end
  end

  assign ack_hit = req_is64 ? i_mwr64_req_ack : i_mwr32_req_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    fail_set  = 1'b0;
    case (state)
      IDLE: begin
        if (i_arb_en && win_vld && !i_mwr_tx_busy && !i_mwr32_req_ack && !i_mwr64_req_ack) begin
          grant     = 1'b1;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        // A zero-length non-udf write would hang the TX controller.
        if (o_req_length == 10'd0 && !o_user_define_data_flag) begin
          fail_set  = 1'b1;
          state_nxt = RELEASE;
        end else begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (ack_hit) begin
          state_nxt = WAIT_TX;
        end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
          fail_set  = 1'b1;
          state_nxt = RELEASE;
        end
      end
      WAIT_TX: begin
        if (!i_mwr_tx_busy && !i_mwr32_req_ack && !i_mwr64_req_ack)
          state_nxt = RELEASE;
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_on = (state == REQ) && (state_nxt == REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ch_gnt                <= '0;
      o_ch_done               <= '0;
      o_ch_err                <= '0;
      o_mwr32_req             <= 1'b0;
      o_mwr64_req             <= 1'b0;
      o_req_length            <= '0;
      o_req_addr              <= '0;
      o_req_data              <= '0;
      o_user_define_data_flag <= 1'b0;
      req_is64                <= 1'b0;
      gnt_idx                 <= '0;
      ptr                     <= '0;
      cnt                     <= '0;
      fail                    <= 1'b0;
    end else begin
      o_ch_done   <= '0;
      o_ch_err    <= '0;
      o_mwr32_req <= req_on && !req_is64;
      o_mwr64_req <= req_on && req_is64;
      if (grant) begin
        o_req_length            <= i_ch_length[10*win_idx +: 10];
        o_req_addr              <= i_ch_addr[64*win_idx +: 64];
        o_req_data              <= i_ch_data[32*win_idx +: 32];
        o_user_define_data_flag <= i_ch_udf[win_idx];
        req_is64                <= i_ch_is64[win_idx];
        gnt_idx                 <= win_idx;
        o_ch_gnt                <= {{(CH_NUM-1){1'b0}}, 1'b1} << win_idx;
        fail                    <= 1'b0;
      end
      if (fail_set)
        fail <= 1'b1;
      if (state == REQ)
        cnt <= cnt + CW'(1);
      // The grant vector doubles as the completion/error pulse vector.
      if (state == RELEASE) begin
        o_ch_gnt <= '0;
        if (fail)
          o_ch_err <= o_ch_gnt;
        else
          o_ch_done <= o_ch_gnt;
        ptr <= (gnt_idx == IW'(CH_NUM - 1)) ? '0 : gnt_idx + IW'(1);
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ips2l_pcie_dma_mwr_req_arb.sv
// tb/tb_ips2l_pcie_dma_mwr_req_arb.sv - directed bench for the MWr request arbiter
module tb_ips2l_pcie_dma_mwr_req_arb;

  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            arb_en;
  logic [CH-1:0]   ch_req, ch_is64, ch_udf;
  logic [CH*10-1:0] ch_length;
  logic [CH*64-1:0] ch_addr;
  logic [CH*32-1:0] ch_data;
  logic [CH-1:0]   gnt, done, err;
  logic            req32, req64;
  logic            m_ack32, m_ack64, x_ack64, tx_busy;
  logic            ack64;
  logic [9:0]      req_length;
  logic [63:0]     req_addr;
  logic [31:0]     req_data;
  logic            req_udf;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  int       busy_left, busy_len;
  logic     ack_en;
  int       overlap, order_err, gnt_cnt, ev_cnt;
  logic [CH-1:0] prev_gnt;
  logic [CH-1:0] gnt_log[$];
  logic [CH-1:0] ev_done, ev_err;

  assign ack64 = m_ack64 | x_ack64;

  ips2l_pcie_dma_mwr_req_arb #(.CH_NUM(CH), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_arb_en(arb_en),
    .i_ch_req(ch_req), .i_ch_is64(ch_is64), .i_ch_udf(ch_udf),
    .i_ch_length(ch_length), .i_ch_addr(ch_addr), .i_ch_data(ch_data),
    .o_ch_gnt(gnt), .o_ch_done(done), .o_ch_err(err),
    .o_mwr32_req(req32), .i_mwr32_req_ack(m_ack32),
    .o_mwr64_req(req64), .i_mwr64_req_ack(ack64),
    .o_req_length(req_length), .o_req_addr(req_addr), .o_req_data(req_data),
    .o_user_define_data_flag(req_udf), .i_mwr_tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // TX controller model: ack one cycle after req, busy for busy_len cycles after ack.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_ack32 = 1'b0; m_ack64 = 1'b0; tx_busy = 1'b0; busy_left = 0;
    end else if (m_ack32 || m_ack64) begin
      m_ack32 = 1'b0; m_ack64 = 1'b0; tx_busy = 1'b1; busy_left = busy_len;
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
      if (busy_left == 0) tx_busy = 1'b0;
    end else if (ack_en) begin
      if (req32) m_ack32 = 1'b1;
      if (req64) m_ack64 = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      gnt_cnt = 0; ev_cnt = 0; prev_gnt = '0; gnt_log.delete();
    end else begin
      if ($countones(gnt) > 1) overlap = overlap + 1;
      if (gnt != '0 && prev_gnt == '0) begin
        if (ev_cnt != gnt_cnt) order_err = order_err + 1;
        gnt_log.push_back(gnt);
        gnt_cnt = gnt_cnt + 1;
      end
      if (done != '0 || err != '0) ev_cnt = ev_cnt + 1;
      prev_gnt = gnt;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic is64, input logic udf, input logic [9:0] len,
                        input logic [63:0] addr, input logic [31:0] data);
    ch_is64[ch]           = is64;
    ch_udf[ch]            = udf;
    ch_length[ch*10 +: 10] = len;
    ch_addr[ch*64 +: 64]  = addr;
    ch_data[ch*32 +: 32]  = data;
  endtask

  task automatic wait_gnt(input string tag);
    int n = 0;
    while (gnt == '0 && n < 200) begin tick(); n++; end
    if (gnt == '0) chk({tag, "_gnt_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic wait_evt(input string tag);
    int n = 0;
    while (done == '0 && err == '0 && n < 200) begin tick(); n++; end
    ev_done = done;
    ev_err  = err;
    if (done == '0 && err == '0) chk({tag, "_evt_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n, rq, err_at;
    logic [CH-1:0] err_v;
    rst_n = 1'b0; arb_en = 1'b1; ch_req = '0; ch_is64 = '0; ch_udf = '0;
    ch_length = '0; ch_addr = '0; ch_data = '0; x_ack64 = 1'b0;
    ack_en = 1'b1; busy_len = 40; overlap = 0; order_err = 0;
    tick(); tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_pulses", {done, err}, 0);
    chk("rst_req", {req32, req64}, 0);
    chk("rst_fields", {req_length, req_data, req_udf}, 0);
    chk("rst_addr", req_addr, 0);
    chk("rst_ptr", dut.ptr, 0);
    rst_n = 1'b1;
    tick();

    // Lone ch0 MWr32 transfer
    set_ch(0, 1'b0, 1'b0, 10'd32, 64'h1000, 32'h0);
    ch_req = 4'b0001;
    tick();
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_len", req_length, 32);
    chk("t1_addr", req_addr, 64'h1000);
    chk("t1_req_t0", req32, 0);
    tick();
    chk("t1_req_t1", req32, 0);
    tick();
    chk("t1_req_t2", {req32, req64}, 2'b10);
    tick();
    chk("t1_req_after_ack", req32, 0);
    ch_length[9:0] = 10'd77;
    tick();
    chk("t1_len_stable", req_length, 32);
    wait_evt("t1");
    chk("t1_done", ev_done, 4'b0001);
    chk("t1_gnt_clr", gnt, 0);
    ch_req = '0;
    tick();
    chk("t1_done_once", done, 0);
    chk("t1_ptr", dut.ptr, 1);

    // All four channels continuously
    do_reset();
    for (int c = 0; c < CH; c++) set_ch(c, 1'b0, 1'b0, 10'd8, 64'h2000 + 64'(c), 32'h0);
    ch_req = 4'hF;
    n = 0;
    for (int i = 0; i < 1000 && n < 5; i++) begin
      tick();
      if (done != '0) n++;
    end
    ch_req = '0;
    tick(); tick();
    chk("t2_ngnt", gnt_log.size(), 5);
    if (gnt_log.size() == 5) begin
      chk("t2_g0", gnt_log[0], 4'b0001);
      chk("t2_g1", gnt_log[1], 4'b0010);
      chk("t2_g2", gnt_log[2], 4'b0100);
      chk("t2_g3", gnt_log[3], 4'b1000);
      chk("t2_g4", gnt_log[4], 4'b0001);
    end
    chk("t2_order", order_err, 0);

    // ch2 MWr64 udf
    set_ch(2, 1'b1, 1'b1, 10'd1, 64'h1_0000_0040, 32'hA5A5_0001);
    ch_req = 4'b0100;
    wait_gnt("t3");
    chk("t3_gnt", gnt, 4'b0100);
    chk("t3_addr", req_addr, 64'h1_0000_0040);
    chk("t3_data", req_data, 32'hA5A5_0001);
    chk("t3_udf_len", {req_udf, req_length}, {1'b1, 10'd1});
    for (int i = 0; i < 10 && !req64; i++) tick();
    chk("t3_req64", {req32, req64}, 2'b01);
    wait_evt("t3");
    chk("t3_done", {ev_done, ev_err}, {4'b0100, 4'b0000});
    ch_req = '0;
    tick();

    // Zero-length reject on ch1, ch2 pending behind it
    set_ch(1, 1'b0, 1'b0, 10'd0, 64'h3000, 32'h0);
    set_ch(2, 1'b0, 1'b0, 10'd4, 64'h4000, 32'h0);
    ch_req = 4'b0110;
    tick();
    chk("t4_gnt", gnt, 4'b0010);
    tick();
    chk("t4_early", {err, req32, req64}, 0);
    tick();
    chk("t4_err", {err, req32, req64}, {4'b0010, 2'b00});
    ch_req = 4'b0100;
    wait_gnt("t4");
    chk("t4_next", gnt, 4'b0100);
    wait_evt("t4");
    chk("t4_done", ev_done, 4'b0100);
    ch_req = '0;
    tick();

    // Ack timeout; a wrong-type ack is present throughout REQ
    ack_en = 1'b0;
    ch_req = 4'b0100;
    tick();
    chk("t5_gnt", gnt, 4'b0100);
    x_ack64 = 1'b1;
    rq = 0; err_at = 0; err_v = '0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (req32) rq++;
      if (err != '0) begin
        err_at = i; err_v = err; ch_req = '0; x_ack64 = 1'b0;
      end
    end
    chk("t5_req_cycles", rq, 15);
    chk("t5_err_at", err_at, 18);
    chk("t5_err", err_v, 4'b0100);
    chk("t5_idle", {gnt, req32, req64}, 0);
    ack_en = 1'b1; x_ack64 = 1'b0;

    // Reset in WAIT_TX
    set_ch(3, 1'b0, 1'b0, 10'd4, 64'h5000, 32'h0);
    set_ch(1, 1'b0, 1'b0, 10'd4, 64'h6000, 32'h0);
    ch_req = 4'b1000;
    wait_gnt("t6");
    chk("t6_gnt", gnt, 4'b1000);
    for (int i = 0; i < 20 && !tx_busy; i++) tick();
    chk("t6_busy", tx_busy, 1);
    ch_req = 4'b1010;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out", {gnt, done, err, req32, req64, req_udf}, 0);
    chk("t6_rst_fields", {req_addr, req_length}, 0);
    chk("t6_rst_ptr", dut.ptr, 0);
    tick();
    rst_n = 1'b1;
    wait_gnt("t6b");
    chk("t6_regnt", gnt, 4'b0010);
    wait_evt("t6b");
    chk("t6_done", ev_done, 4'b0010);
    ch_req = '0;
    tick();
    chk("no_overlap", overlap, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
